// File: rtl/axi4lite_timer_bank.sv
// AXI4-Lite slave with NUM_CH independent down-counting timers.
// Each channel exposes CTRL, LOAD, COUNT and a sticky W1C STATUS register plus an irq line.
module axi4lite_timer_bank #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int CW     = 32,
  parameter int NUM_CH = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [AW-1:0]     AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DW-1:0]     WDATA,
  input  logic [DW/8-1:0]   WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [AW-1:0]     ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DW-1:0]     RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [NUM_CH-1:0] irq
);
  localparam int SW = DW / 8;
  localparam int CHW = AW - 4;
  localparam logic [CHW:0] NUM_CH_L = (CHW + 1)'(NUM_CH);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              rst_done;
  logic              aw_held, w_held;
  logic [AW-1:2]     aw_addr_q;
  logic [DW-1:0]     w_data_q;
  logic [SW-1:0]     w_strb_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DW-1:0]     rdata_q;

  logic [NUM_CH-1:0] en, ar, ie, exp;
  logic [CW-1:0]     load  [NUM_CH];
  logic [CW-1:0]     count [NUM_CH];

  logic              aw_ready, w_ready, ar_ready, do_write, wr_ok, rd_ok;
  logic [CHW-1:0]    wr_ch, rd_ch;
  logic [1:0]        wr_off, rd_off;
  logic [DW-1:0]     wr_old, wr_new, rd_word;
  logic              unused_addr_bits;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int k = 0; k < SW; k++)
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  assign aw_ready = rst_done & ~aw_held & ~bvalid_q;
  assign w_ready  = rst_done & ~w_held & ~bvalid_q;
  assign ar_ready = rst_done & ~rvalid_q;
  assign do_write = aw_held & w_held;
  assign wr_ch    = aw_addr_q[AW-1:4];
  assign wr_off   = aw_addr_q[3:2];
  assign rd_ch    = ARADDR[AW-1:4];
  assign rd_off   = ARADDR[3:2];
  assign wr_ok    = {1'b0, wr_ch} < NUM_CH_L;
  assign rd_ok    = {1'b0, rd_ch} < NUM_CH_L;

  // Outputs are forced low for the whole time reset is held, including its first cycle.
  assign AWREADY = aw_ready & ~ARESET;
  assign WREADY  = w_ready & ~ARESET;
  assign ARREADY = ar_ready & ~ARESET;
  assign BVALID  = bvalid_q & ~ARESET;
  assign BRESP   = ARESET ? 2'b00 : bresp_q;
  assign RVALID  = rvalid_q & ~ARESET;
  assign RRESP   = ARESET ? 2'b00 : rresp_q;
  assign RDATA   = ARESET ? '0 : rdata_q;
  assign irq     = ARESET ? '0 : (exp & ie);

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (wr_ch == CHW'(i))
        wr_old = (wr_off == 2'd0) ? DW'({ie[i], ar[i], en[i]}) : DW'(load[i]);
    wr_new = merge(wr_old, w_data_q, w_strb_q);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CHW'(i))
        case (rd_off)
          2'd0:    rd_word = DW'({ie[i], ar[i], en[i]});
          2'd1:    rd_word = DW'(load[i]);
          2'd2:    rd_word = DW'(count[i]);
          default: rd_word = DW'(exp[i]);
        endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rst_done  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (AWVALID && aw_ready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR[AW-1:2];
      end
      if (WVALID && w_ready) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (do_write) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
      // Register values are sampled before this edge's updates, so a colliding read sees old data.
      if (ARVALID && ar_ready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_ok ? rd_word : '0;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Bus writes are assigned after the timer update so they take priority, except expiry beats W1C.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en  <= '0;
      ar  <= '0;
      ie  <= '0;
      exp <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        load[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en[i]) begin
          if (count[i] != '0) begin
            count[i] <= count[i] - CW'(1);
          end else begin
            exp[i] <= 1'b1;
            if (ar[i]) count[i] <= load[i];
            else       en[i]    <= 1'b0;
          end
        end
        if (do_write && wr_ok && wr_ch == CHW'(i)) begin
          case (wr_off)
            2'd0: if (w_strb_q[0]) begin
              en[i] <= wr_new[0];
              ar[i] <= wr_new[1];
              ie[i] <= wr_new[2];
            end
            2'd1: if (|w_strb_q) begin
              load[i]  <= wr_new[CW-1:0];
              count[i] <= wr_new[CW-1:0];
            end
            2'd3: if (w_strb_q[0] && w_data_q[0] && !(en[i] && count[i] == '0))
              exp[i] <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/axi4lite_timer_bank.md
Name: axi4lite_timer_bank

Overview:
- Parametrised AXI4-Lite slave containing NUM_CH independent down-counting timers, each with per-channel control, reload, count and sticky-status registers, and an interrupt output per channel.
- Next-generation peripheral on the team's AXI4-Lite fabric: generalises the single-timer slave in address width, data width, counter width and channel count.
- Adds independent AW/W acceptance, byte strobes, auto-reload and SLVERR decoding.

Parameters:
- AW, 8, address width in bits; must be >= $clog2(NUM_CH)+4.
- DW, 32, data width in bits; 32 or 64. Strobe width is DW/8.
- CW, 32, counter width in bits; must be <= DW.
- NUM_CH, 4, number of timer channels, 1..16.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  AW  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DW  write data.
- WSTRB  in  DW/8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response; 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  AW  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DW  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- irq  out  NUM_CH  per-channel interrupt; irq[i] = STATUS[i].exp & CTRL[i].ie.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While ARESET=1, every output is 0: all READY/VALID signals, BRESP, RRESP, RDATA and irq.
  - All registers clear to 0.
  - The cycle after ARESET falls, AWREADY, WREADY and ARREADY go to 1.
  - Reset mid-transaction drops any pending AW/W/B/R state; no response is issued.
- Address map: channel = ADDR[AW-1:4], offset = ADDR[3:2]; ADDR[1:0] are ignored.
  - Offset 0 CTRL: bit0 en, bit1 auto-reload (ar), bit2 ie.
  - Offset 1 LOAD: CW bits.
  - Offset 2 COUNT: read-only.
  - Offset 3 STATUS: bit0 exp, write-1-to-clear.
  - Unused bits read 0 and CW-wide values are zero-extended to DW.
- Write channel:
  - AW and W are captured independently into holding registers. AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID.
  - The register update occurs in the cycle after both are held. BVALID rises in that same cycle and both holds clear.
  - BVALID is held, with BRESP stable, until BREADY=1; it falls the cycle after the handshake.
  - WSTRB[k]=1 updates byte k only; WSTRB=0 gives OKAY with no change.
  - Writes to COUNT give OKAY and are ignored.
  - Writing LOAD also loads COUNT with the resulting LOAD value.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle. Read latency is 1.
  - RDATA/RRESP are held stable until RREADY=1.
- Decode error: channel >= NUM_CH gives SLVERR (10). The write is dropped; the read returns RDATA=0.
- Timer per channel, each cycle with en=1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: exp is set to 1. If ar=1, COUNT reloads from LOAD. If ar=0, en is cleared to 0 and COUNT stays at 0.
  - en=0 freezes COUNT.
- Simultaneous events:
  - Hardware expiry and a STATUS W1C write in the same cycle: set wins, exp=1.
  - A bus write to CTRL.en in the cycle of an ar=0 expiry: the bus value wins.
  - A LOAD write in the same cycle as a decrement: the LOAD write wins.
  - Read and write to the same register in one cycle: the read returns the pre-write value.
- Wrap-around: LOAD=0 with ar=1 gives expiry every cycle. COUNT never underflows.

Test Plan:
- Reset and defaults: assert ARESET for 3 cycles -> all outputs 0. One cycle after release, AWREADY=WREADY=ARREADY=1. Reading ch0 CTRL/LOAD/COUNT/STATUS returns 0 with RRESP=00.
- One-shot: write LOAD[1]=5, then CTRL[1]=0x5 (en, ie) -> COUNT counts 5..0. exp=1 and irq[1]=1 on the zero cycle+1; en reads back 0; COUNT stays 0. Write STATUS=1 -> irq[1]=0.
- Auto-reload: LOAD[0]=3, CTRL[0]=0x3 -> exp sets every 4 cycles and COUNT sequence 3,2,1,0,3. W1C issued in the expiry cycle -> exp stays 1.
- Independent AW/W with strobes: present W (WDATA=0xAABBCCDD, WSTRB=0x3) 4 cycles before AW to LOAD[2] -> WREADY drops after capture; BVALID appears 1 cycle after AW; LOAD[2]=0x0000CCDD. Hold BREADY=0 for 5 cycles -> BVALID and BRESP stay stable, AWREADY=WREADY=0.
- Decode error: write and read to channel 5 with NUM_CH=4 -> BRESP=10, RRESP=10, RDATA=0, no register changes.
- Backpressure and reset mid-read: AR issued with RREADY=0 -> RVALID held and ARREADY=0. Assert ARESET -> next cycle RVALID=0, registers cleared, no response delivered.
